// File: rtl/uart_tx_frame_ctrl_if.sv
// uart_tx_frame_ctrl_if: upstream word strobe, serializer link and TX line of the UART transmitter
interface uart_tx_frame_ctrl_if #(parameter int width = 8);
   logic [width-1:0] Data;
   logic Data_valid;
   logic PAR_EN;
   logic PAR_TYP;
   logic Ser_data;
   logic Ser_done;
   logic Ser_EN;
   logic Busy;
   logic valid_instop;
   logic TX_OUT;
   modport master (
      output Data, Data_valid, PAR_EN, PAR_TYP, Ser_data, Ser_done,
      input  Ser_EN, Busy, valid_instop, TX_OUT
   );
   modport slave (
      input  Data, Data_valid, PAR_EN, PAR_TYP, Ser_data, Ser_done,
      output Ser_EN, Busy, valid_instop, TX_OUT
   );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: UART frame sequencer (start, data LSB first, parity, stop) driving the serializer.
// Macro UART_TX_PARITY_EN enables the parity bit; without it PAR_EN/PAR_TYP are ignored.
module uart_tx_frame_ctrl #(
   parameter int width = 8
) (
   input logic CLK,
   input logic Reset,
   uart_tx_frame_ctrl_if.slave bus
);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t state_q, state_d;
`ifdef UART_TX_PARITY_EN
   logic accept;
   logic parity_q, parity_d;
   logic par_en_q, par_en_d;
   logic par_typ_q, par_typ_d;
   assign accept = bus.Data_valid && (state_q == IDLE || state_q == STOP);
   // parity is fixed at accept time so upstream may change Data during the frame
   always_comb begin
      parity_d = accept ? (^bus.Data) ^ bus.PAR_TYP : parity_q;
      par_en_d = accept ? bus.PAR_EN : par_en_q;
      par_typ_d = accept ? bus.PAR_TYP : par_typ_q;
   end
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= IDLE;
         parity_q <= 1'b0;
         par_en_q <= 1'b0;
         par_typ_q <= 1'b0;
      end else begin
         state_q <= state_d;
         parity_q <= parity_d;
         par_en_q <= par_en_d;
         par_typ_q <= par_typ_d;
      end
   end
`else
   logic unused_par_inputs;
   assign unused_par_inputs = ^{bus.Data, bus.PAR_EN, bus.PAR_TYP};
   always_ff @(posedge CLK) begin
      if (Reset) state_q <= IDLE;
      else state_q <= state_d;
   end
`endif
   // end of the data phase comes only from Ser_done; bits are not counted here
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = bus.Data_valid ? START : IDLE;
         START: state_d = DATA;
`ifdef UART_TX_PARITY_EN
         DATA: state_d = bus.Ser_done ? (par_en_q ? PARITY : STOP) : DATA;
         PARITY: state_d = STOP;
`else
         DATA: state_d = bus.Ser_done ? STOP : DATA;
`endif
         STOP: state_d = bus.Data_valid ? START : IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign bus.Busy = state_q != IDLE;
   assign bus.Ser_EN = state_q == START || (state_q == DATA && !bus.Ser_done);
   assign bus.valid_instop = state_q == STOP && bus.Data_valid;
`ifdef UART_TX_PARITY_EN
   assign bus.TX_OUT = state_q == START ? 1'b0 :
                       state_q == DATA ? bus.Ser_data :
                       state_q == PARITY ? parity_q : 1'b1;
`else
   assign bus.TX_OUT = state_q == START ? 1'b0 :
                       state_q == DATA ? bus.Ser_data : 1'b1;
`endif
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb_uart_tx_frame_ctrl: directed frame vectors plus back-to-back, spurious-strobe and reset sequences.
module tb_uart_tx_frame_ctrl;
   localparam int W = 8;
   typedef struct {
      logic [7:0] d;
      logic pe;
      logic pt;
      logic [11:0] line;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_bad = 0;
   vec_t tv [9];
   always #5 clk = ~clk;
   uart_tx_frame_ctrl_if #(.width(W)) bus ();
   uart_tx_frame_ctrl #(.width(W)) dut (.CLK(clk), .Reset(rst), .bus(bus));
   // serializer stand-in: loads when the controller would accept, shifts one bit per Ser_EN
   logic [W-1:0] sreg;
   logic [3:0] scnt;
   logic sout;
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= '0;
         scnt <= '0;
         sout <= 1'b0;
      end else if (bus.Data_valid && (!bus.Busy || bus.valid_instop)) begin
         sreg <= bus.Data;
         scnt <= '0;
      end else if (bus.Ser_EN) begin
         sout <= sreg[0];
         sreg <= sreg >> 1;
         scnt <= scnt + 4'd1;
      end
   end
   assign bus.Ser_data = sout;
   assign bus.Ser_done = scnt == 4'(W);
   function automatic logic [11:0] eff_line(input logic [11:0] l);
`ifdef UART_TX_PARITY_EN
      return l;
`else
      return {3'b111, l[8:0]};
`endif
   endfunction
   function automatic int eff_len(input logic pe);
`ifdef UART_TX_PARITY_EN
      return pe ? 11 : 10;
`else
      return pe ? 10 : 10;
`endif
   endfunction
   task automatic chk(input string nm, input logic act, input logic exp, input int c);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %b want %b", nm, c, act, exp);
      end
   endtask
   task automatic drive(input logic [7:0] d, input logic pe, input logic pt);
      bus.Data = d;
      bus.PAR_EN = pe;
      bus.PAR_TYP = pt;
      bus.Data_valid = 1'b1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         chk("idle_tx", bus.TX_OUT, 1'b1, i);
         chk("idle_busy", bus.Busy, 1'b0, i);
         chk("idle_ser_en", bus.Ser_EN, 1'b0, i);
         chk("idle_instop", bus.valid_instop, 1'b0, i);
      end
   endtask
   // mode 0: plain frame, 1: strobe next word in the stop cycle, 2: spurious strobe mid-DATA
   task automatic watch(input logic [11:0] line, input logic pe, input int ncyc, input int mode,
                        input logic [7:0] nd, input logic npe, input logic npt);
      logic [11:0] l;
      int len;
      l = eff_line(line);
      len = eff_len(pe);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         bus.Data_valid = 1'b0;
         if (mode == 1 && c == len - 1) drive(nd, npe, npt);
         if (mode == 2 && c == 4) drive(8'hFF, 1'b1, 1'b1);
         #1;
         chk("tx", bus.TX_OUT, l[c], c);
         chk("busy", bus.Busy, c < len, c);
         chk("ser_en", bus.Ser_EN, c < 8, c);
         chk("instop", bus.valid_instop, mode == 1 && c == len - 1, c);
      end
   endtask
   initial begin
      // line bits in time order from the cycle after accept: {idle, stop, parity, d7..d0, start}
      tv[0] = '{8'hA5, 1'b1, 1'b0, 12'b1_1_0_10100101_0};
      tv[1] = '{8'hA5, 1'b1, 1'b1, 12'b1_1_1_10100101_0};
      tv[2] = '{8'hA5, 1'b0, 1'b0, 12'b1_1_1_10100101_0};
      tv[3] = '{8'h00, 1'b1, 1'b1, 12'b1_1_1_00000000_0};
      tv[4] = '{8'h00, 1'b1, 1'b0, 12'b1_1_0_00000000_0};
      tv[5] = '{8'hFF, 1'b1, 1'b0, 12'b1_1_0_11111111_0};
      tv[6] = '{8'h3C, 1'b1, 1'b1, 12'b1_1_1_00111100_0};
      tv[7] = '{8'h01, 1'b1, 1'b0, 12'b1_1_1_00000001_0};
      tv[8] = '{8'h80, 1'b0, 1'b1, 12'b1_1_1_10000000_0};
      bus.Data = '0;
      bus.Data_valid = 1'b0;
      bus.PAR_EN = 1'b0;
      bus.PAR_TYP = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(5);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive(tv[i].d, tv[i].pe, tv[i].pt);
         watch(tv[i].line, tv[i].pe, 12, 0, 8'h00, 1'b0, 1'b0);
      end
      @(negedge clk);
      drive(8'h0F, 1'b1, 1'b0);
      watch(12'b1_1_0_00001111_0, 1'b1, eff_len(1'b1), 1, 8'hF0, 1'b1, 1'b1);
      watch(12'b1_1_1_11110000_0, 1'b1, 12, 0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      drive(8'h5A, 1'b0, 1'b0);
      watch(12'b1_1_1_01011010_0, 1'b0, 12, 2, 8'h00, 1'b0, 1'b0);
      idle(4);
      @(negedge clk);
      drive(8'hA5, 1'b1, 1'b0);
      watch(12'b1_1_0_10100101_0, 1'b1, 5, 0, 8'h00, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_tx", bus.TX_OUT, 1'b1, 0);
      chk("rst_busy", bus.Busy, 1'b0, 0);
      chk("rst_ser_en", bus.Ser_EN, 1'b0, 0);
      rst = 1'b0;
      idle(2);
      @(negedge clk);
      drive(8'h3C, 1'b1, 1'b1);
      watch(12'b1_1_1_00111100_0, 1'b1, 12, 0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      drive(8'h81, 1'b1, 1'b0);
      @(negedge clk);
      bus.Data_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_wins_busy", bus.Busy, 1'b0, 0);
      chk("rst_wins_tx", bus.TX_OUT, 1'b1, 0);
      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
